// File: rtl/uc_pkg.sv
// Shared opcodes, FSM states and control bundle for the uc_seq sequencing unit.
package uc_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_LI   = 6'b000001;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JZ   = 6'b000011;
  localparam logic [5:0] OP_JNZ  = 6'b000100;
  localparam logic [5:0] OP_WAIT = 6'b000101;
  localparam logic [5:0] OP_HALT = 6'b000110;
  localparam logic       OP_ALU_PREFIX = 1'b1;
  localparam logic [2:0] ALU_PASS = 3'b000;

  typedef enum logic [2:0] {BOOT, RUN, WAIT, HALT, STEP} state_t;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
    logic       pc_en;
  } ctrl_t;

  // PC held, no writes, sequential PC select: used in reset, BOOT, WAIT and HALT.
  localparam ctrl_t CTRL_SAFE = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0,
                                  op: ALU_PASS, pc_en: 1'b0};

endpackage

// File: rtl/uc_decoder.sv
// Combinational opcode decoder: Opcode + zero flag -> datapath control bundle
// plus WAIT / HALT / illegal classification for the sequencer.
module uc_decoder
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output ctrl_t      ctrl,
  output logic       is_wait,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    ctrl       = CTRL_SAFE;
    is_wait    = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    if (opcode[5] == OP_ALU_PREFIX) begin
      ctrl.op    = opcode[4:2];
      ctrl.we3   = 1'b1;
      ctrl.wez   = 1'b1;
      ctrl.pc_en = 1'b1;
    end else begin
      case (opcode)
        OP_NOP: ctrl.pc_en = 1'b1;
        OP_LI: begin
          ctrl.s_inm = 1'b1;
          ctrl.we3   = 1'b1;
          ctrl.pc_en = 1'b1;
        end
        OP_J: begin
          ctrl.s_inc = 1'b0;
          ctrl.pc_en = 1'b1;
        end
        // z is the flag committed by the previous instruction
        OP_JZ: begin
          ctrl.s_inc = ~z;
          ctrl.pc_en = 1'b1;
        end
        OP_JNZ: begin
          ctrl.s_inc = z;
          ctrl.pc_en = 1'b1;
        end
        OP_WAIT: is_wait = 1'b1;
        OP_HALT: begin
          ctrl.pc_en = 1'b1;
          is_halt    = 1'b1;
        end
        default: begin
          ctrl.pc_en = 1'b1;
          is_illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uc_seq.sv
// Sequencing control unit: decode, timed WAIT stall, HALT and debug step/resume.
// Build option UC_ILLEGAL_TRAP_EN: illegal opcodes hold the PC and enter HALT.
module uc_seq
  import uc_pkg::*;
#(
  parameter int WAIT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       z,
  input  logic       dbg_halt_req,
  input  logic       dbg_step_req,
  input  logic       dbg_resume_req,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we3,
  output logic       wez,
  output logic [2:0] Op,
  output logic       pc_en,
  output logic       halted,
  output logic       illegal,
  output logic [2:0] dbg_state
);

`ifdef UC_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             step_pending;
  ctrl_t            dec_ctrl;
  ctrl_t            out;
  logic             is_wait, is_halt, is_illegal;
  logic             active, trap;

  uc_decoder u_dec (
    .opcode     (Opcode),
    .z          (z),
    .ctrl       (dec_ctrl),
    .is_wait    (is_wait),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  assign active = (state == RUN) || (state == STEP);
  assign trap   = active && is_illegal && TRAP_EN;

  always_comb begin
    out = CTRL_SAFE;
    case (state)
      RUN, STEP: out = trap ? CTRL_SAFE : dec_ctrl;
      // last wait cycle releases the PC unless a debug halt aborts the wait
      WAIT:      out.pc_en = (wait_cnt == CNT_ONE) && !dbg_halt_req;
      default:   out = CTRL_SAFE;
    endcase
  end

  assign s_inc     = out.s_inc;
  assign s_inm     = out.s_inm;
  assign we3       = out.we3;
  assign wez       = out.wez;
  assign Op        = out.op;
  assign pc_en     = out.pc_en;
  assign halted    = (state == HALT);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      wait_cnt     <= '0;
      step_pending <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      if (active && is_illegal) illegal <= 1'b1;
      case (state)
        BOOT: state <= RUN;
        RUN, STEP: begin
          if (trap) begin
            state <= HALT;
          end else if (is_wait) begin
            if (state == RUN && dbg_halt_req) begin
              state <= HALT;
            end else begin
              state        <= WAIT;
              wait_cnt     <= WAIT_LOAD;
              step_pending <= (state == STEP);
            end
          end else if (state == STEP || is_halt || dbg_halt_req) begin
            state <= HALT;
          end else begin
            state <= RUN;
          end
        end
        WAIT: begin
          if (dbg_halt_req) begin
            state        <= HALT;
            wait_cnt     <= '0;
            step_pending <= 1'b0;
          end else if (wait_cnt == CNT_ONE) begin
            state        <= step_pending ? HALT : RUN;
            wait_cnt     <= '0;
            step_pending <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - CNT_ONE;
          end
        end
        HALT: begin
          if (dbg_resume_req)    state <= RUN;
          else if (dbg_step_req) state <= STEP;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
